// File: rtl/aes_mode_pkg.sv
// ---------------------------------------------------------------------------
// aes_mode_pkg
// Shared definitions for the block-cipher mode controller:
//   BLOCK_W  - AES block width in bits
//   mode_t   - chaining mode encodings presented on the mode input
//   state_t  - controller FSM states (also exported on the debug port)
//   ctr_inc  - counter increment confined to the bits selected by a mask
// ---------------------------------------------------------------------------
package aes_mode_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    MODE_ECB  = 2'b00,
    MODE_CBC  = 2'b01,
    MODE_CTR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IN   = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_OUT       = 3'd4
  } state_t;

  // Increment only the masked (low) bits; the carry out of the masked field
  // is discarded so the upper bits of the counter block never change.
  function automatic logic [BLOCK_W-1:0] ctr_inc(input logic [BLOCK_W-1:0] ctr,
                                                 input logic [BLOCK_W-1:0] mask);
    return (ctr & ~mask) | ((ctr + 128'd1) & mask);
  endfunction

endpackage

// File: rtl/aes_mode_ctrl.sv
// ---------------------------------------------------------------------------
// aes_mode_ctrl
// ECB / CBC / CTR chaining controller placed in front of an external
// single-block AES core.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds valid and its payload stable until that edge,
// and ready never depends combinationally on valid.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   msg_start           pulse: latch mode/dir/key/iv (ignored while busy)
//   mode, dir, key, iv  message configuration
//   in_valid/in_ready   input block handshake, in_data/in_last payload
//   out_valid/out_ready output block handshake, out_data/out_last payload
//   busy, err           message in progress / sticky error
//   core_*              connection to the external AES core
//   state_dbg           current FSM state
// ---------------------------------------------------------------------------
module aes_mode_ctrl
  import aes_mode_pkg::*;
#(
  parameter int CTR_WIDTH = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               msg_start,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [BLOCK_W-1:0] key,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               err,
  output logic [BLOCK_W-1:0] core_data,
  output logic [BLOCK_W-1:0] core_key,
  output logic               core_start_enc,
  output logic               core_start_dec,
  input  logic               core_done_enc,
  input  logic               core_done_dec,
  input  logic [BLOCK_W-1:0] core_cipher,
  input  logic [BLOCK_W-1:0] core_plain,
  output state_t             state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [BLOCK_W-1:0] CTR_MASK = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_WIDTH);

  state_t             state_q, state_d;
  mode_t              mode_q;
  logic               dir_q;
  // Holds the CBC chaining value, or the counter block in CTR mode.
  logic [BLOCK_W-1:0] chain_q;
  logic [BLOCK_W-1:0] in_q;
  logic               last_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               issued_dec;
  logic               done_hit;
  logic               timeout_hit;
  logic [BLOCK_W-1:0] result;
  logic [BLOCK_W-1:0] issue_data;
  logic [BLOCK_W-1:0] out_next;
  logic [BLOCK_W-1:0] chain_next;

  // CTR always runs the core forward, whatever dir says.
  assign issued_dec  = dir_q && (mode_q != MODE_CTR);
  assign done_hit    = (state_q == ST_WAIT_CORE) &&
                       (issued_dec ? core_done_dec : core_done_enc);
  // A done in the same cycle as the limit wins over the timeout.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));
  assign result      = issued_dec ? core_plain : core_cipher;

  assign in_ready       = (state_q == ST_WAIT_IN);
  assign out_valid      = (state_q == ST_OUT);
  assign busy           = (state_q != ST_IDLE);
  assign core_start_enc = (state_q == ST_ISSUE) && !issued_dec;
  assign core_start_dec = (state_q == ST_ISSUE) && issued_dec;
  assign state_dbg      = state_q;

  // Block presented to the core, captured on the input handshake.
  always_comb begin
    issue_data = in_data;
    case (mode_q)
      MODE_CBC: if (!dir_q) issue_data = in_data ^ chain_q;
      MODE_CTR: issue_data = chain_q;
      default:  ;
    endcase
  end

  // Output block and next chaining value, captured on the matching done.
  always_comb begin
    out_next   = result;
    chain_next = chain_q;
    case (mode_q)
      MODE_CBC: begin
        if (dir_q) begin
          out_next   = result ^ chain_q;
          chain_next = in_q;
        end else begin
          chain_next = result;
        end
      end
      MODE_CTR: begin
        out_next   = in_q ^ result;
        chain_next = ctr_inc(chain_q, CTR_MASK);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (msg_start && (mode != MODE_RSVD)) state_d = ST_WAIT_IN;
      ST_WAIT_IN:   if (in_valid) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_CORE;
      ST_WAIT_CORE: begin
        if (done_hit)         state_d = ST_OUT;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_OUT:       if (out_ready) state_d = last_q ? ST_IDLE : ST_WAIT_IN;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= MODE_ECB;
      dir_q     <= 1'b0;
      chain_q   <= '0;
      in_q      <= '0;
      last_q    <= 1'b0;
      wait_cnt  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      core_data <= '0;
      core_key  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (msg_start) begin
            if (mode == MODE_RSVD) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              mode_q   <= mode_t'(mode);
              dir_q    <= dir;
              core_key <= key;
              chain_q  <= iv;
            end
          end
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            in_q      <= in_data;
            last_q    <= in_last;
            core_data <= issue_data;
          end
        end
        ST_ISSUE: wait_cnt <= '0;
        ST_WAIT_CORE: begin
          if (done_hit) begin
            out_data <= out_next;
            out_last <= last_q;
            chain_q  <= chain_next;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_OUT: if (out_ready) out_last <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
module tb_aes_mode_ctrl;
  import aes_mode_pkg::*;

  localparam int TB_TIMEOUT = 8;

  // Known AES-128 vectors; the bench plays the part of the AES core.
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] C2  = 128'h29c3505f571420f6402299b31a02d73a;
  localparam logic [127:0] P2  = 128'h54776f204f6e65204e696e652054776f;
  localparam logic [127:0] PB2 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CB2 = 128'hdeadbeef0badf00dcafebabe12345678;
  localparam logic [127:0] W0  = 128'h0123456789abcdef01234567ffffffff;
  localparam logic [127:0] W1  = 128'h0123456789abcdef0123456700000000;
  localparam logic [127:0] X1  = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
  localparam logic [127:0] X2  = 128'h11112222333344445555666677778888;
  localparam logic [127:0] R1  = 128'h13579bdf2468ace0fedcba9876543210;
  localparam logic [127:0] R2  = 128'h00000000ffffffff00000000ffffffff;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         msg_start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         dir = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;
  logic [127:0] core_data;
  logic [127:0] core_key;
  logic         core_start_enc;
  logic         core_start_dec;
  logic         core_done_enc = 1'b0;
  logic         core_done_dec = 1'b0;
  logic [127:0] core_cipher = '0;
  logic [127:0] core_plain = '0;
  state_t       state_dbg;

  int n_cmp = 0;
  int n_mis = 0;

  aes_mode_ctrl #(.CTR_WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .msg_start(msg_start), .mode(mode), .dir(dir),
    .key(key), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err), .core_data(core_data), .core_key(core_key),
    .core_start_enc(core_start_enc), .core_start_dec(core_start_dec),
    .core_done_enc(core_done_enc), .core_done_dec(core_done_dec),
    .core_cipher(core_cipher), .core_plain(core_plain), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_msg(input logic [1:0] m, input logic d,
                           input logic [127:0] k, input logic [127:0] v);
    msg_start = 1'b1; mode = m; dir = d; key = k; iv = v;
    tick();
    msg_start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_in_ready", in_ready, 1'b1);
    check("start_err_clear", err, 1'b0);
  endtask

  // Offer one block; returns just after the handshake edge (ISSUE cycle).
  task automatic send_block(input logic [127:0] d, input logic last);
    bit done = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  // Check the start pulse, answer after lat WAIT_CORE cycles, check out_valid.
  task automatic serve(input string tag, input logic [127:0] exp_cd,
                       input logic [127:0] exp_key, input logic exp_dec,
                       input logic [127:0] res, input int lat, input bit wrong);
    int left = lat - 1;
    check({tag, "_start_enc"}, core_start_enc, !exp_dec);
    check({tag, "_start_dec"}, core_start_dec, exp_dec);
    check({tag, "_core_data"}, core_data, exp_cd);
    check({tag, "_core_key"}, core_key, exp_key);
    tick();
    check({tag, "_single_pulse"}, {core_start_enc, core_start_dec}, 2'b00);
    if (wrong && left > 0) begin
      // Done of the opposite type with junk results must be ignored.
      core_done_enc = exp_dec; core_done_dec = !exp_dec;
      core_cipher = '1; core_plain = '1;
      tick();
      core_done_enc = 1'b0; core_done_dec = 1'b0;
      left--;
      check({tag, "_wrong_done_ignored"}, out_valid, 1'b0);
    end
    for (int i = 0; i < left; i++) tick();
    if (exp_dec) begin core_done_dec = 1'b1; core_plain = res; end
    else         begin core_done_enc = 1'b1; core_cipher = res; end
    tick();
    core_done_enc = 1'b0; core_done_dec = 1'b0;
    core_cipher = '0; core_plain = '0;
    check({tag, "_out_valid"}, out_valid, 1'b1);
  endtask

  task automatic recv(input string tag, input logic [127:0] exp_d,
                      input logic exp_last, input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_data"}, out_data, exp_d);
      check({tag, "_hold_no_start"}, {core_start_enc, core_start_dec, in_ready}, 3'b000);
    end
    check({tag, "_out_data"}, out_data, exp_d);
    check({tag, "_out_last"}, out_last, exp_last);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_after_out"}, {out_valid, busy, in_ready}, exp_last ? 3'b000 : 3'b011);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick();
    tick();
    check("rst_ctrl", {in_ready, out_valid, out_last, busy, err, core_start_enc, core_start_dec}, 7'b0);
    check("rst_data", out_data | core_data | core_key, 128'h0);
    check("rst_state", 128'(state_dbg), 128'(ST_IDLE));
    reset = 1'b1;
    tick();

    // ECB encrypt with a wrong-type done injected during the wait.
    start_msg(2'b00, 1'b0, K1, '0);
    send_block(P1, 1'b1);
    serve("ecb_enc", P1, K1, 1'b0, C1, 3, 1'b1);
    recv("ecb_enc", C1, 1'b1, 0);

    // ECB decrypt.
    start_msg(2'b00, 1'b1, K2, '0);
    send_block(C2, 1'b1);
    serve("ecb_dec", C2, K2, 1'b1, P2, 2, 1'b0);
    recv("ecb_dec", P2, 1'b1, 0);

    // CBC encrypt, iv = 0, two blocks, consumer stalls on the first.
    start_msg(2'b01, 1'b0, K1, '0);
    send_block(P1, 1'b0);
    serve("cbc_enc1", P1, K1, 1'b0, C1, 2, 1'b0);
    recv("cbc_enc1", C1, 1'b0, 5);
    send_block(PB2, 1'b1);
    serve("cbc_enc2", PB2 ^ C1, K1, 1'b0, CB2, 1, 1'b0);
    recv("cbc_enc2", CB2, 1'b1, 0);

    // CBC decrypt of the same ciphertext restores the plaintext.
    start_msg(2'b01, 1'b1, K1, '0);
    send_block(C1, 1'b0);
    serve("cbc_dec1", C1, K1, 1'b1, P1, 2, 1'b1);
    recv("cbc_dec1", P1, 1'b0, 0);
    send_block(CB2, 1'b1);
    serve("cbc_dec2", CB2, K1, 1'b1, PB2 ^ C1, 2, 1'b0);
    recv("cbc_dec2", PB2, 1'b1, 0);

    // CTR single block: keystream XOR zero plaintext.
    start_msg(2'b10, 1'b1, K1, P1);
    send_block('0, 1'b1);
    serve("ctr", P1, K1, 1'b0, C1, 2, 1'b0);
    recv("ctr", C1, 1'b1, 0);

    // CTR low-word wrap without carry into the upper 96 bits.
    start_msg(2'b10, 1'b0, K2, W0);
    send_block(X1, 1'b0);
    serve("ctr_w1", W0, K2, 1'b0, R1, 1, 1'b0);
    recv("ctr_w1", X1 ^ R1, 1'b0, 0);
    send_block(X2, 1'b1);
    serve("ctr_w2", W1, K2, 1'b0, R2, 2, 1'b0);
    recv("ctr_w2", X2 ^ R2, 1'b1, 0);

    // Reserved mode.
    msg_start = 1'b1; mode = 2'b11;
    tick();
    msg_start = 1'b0;
    check("rsvd_err_busy", {err, busy, in_ready}, 3'b100);

    // Next start clears err; a start while busy is ignored.
    start_msg(2'b00, 1'b0, K1, '0);
    msg_start = 1'b1; mode = 2'b11;
    tick();
    msg_start = 1'b0;
    check("busy_start_ignored", {err, busy, in_ready}, 3'b011);

    // Timeout: done withheld.
    send_block(P1, 1'b1);
    check("to_start", core_start_enc, 1'b1);
    for (int i = 0; i < TB_TIMEOUT + 1; i++) tick();
    check("to_at_limit", {err, busy}, 2'b01);
    tick();
    check("to_err", {err, busy, out_valid}, 3'b100);
    check("to_state", 128'(state_dbg), 128'(ST_IDLE));

    // Done exactly at the limit still succeeds.
    start_msg(2'b00, 1'b0, K1, '0);
    send_block(P1, 1'b1);
    serve("limit", P1, K1, 1'b0, C1, TB_TIMEOUT + 1, 1'b0);
    recv("limit", C1, 1'b1, 0);
    check("limit_no_err", err, 1'b0);

    // Reset asserted in WAIT_CORE.
    start_msg(2'b01, 1'b0, K2, P2);
    send_block(P1, 1'b1);
    tick();
    check("rstmid_in_wait", 128'(state_dbg), 128'(ST_WAIT_CORE));
    reset = 1'b0;
    tick();
    check("rstmid_ctrl", {in_ready, out_valid, out_last, busy, err, core_start_enc, core_start_dec}, 7'b0);
    check("rstmid_data", out_data | core_data | core_key, 128'h0);
    check("rstmid_state", 128'(state_dbg), 128'(ST_IDLE));
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstmid_no_start", {core_start_enc, core_start_dec, busy}, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/aes_mode_ctrl.md
# aes_mode_ctrl

Block-cipher mode controller that sits between a streaming data source/sink and the existing single-block AES core, which has start/done handshakes for encryption and decryption. It adds ECB, CBC and CTR chaining over multi-block messages, with valid/ready flow control, a parametrised counter width and a core-response timeout. The AES core remains a separate instance, wired to this block by the parent.

## Interface
Parameters:
- CTR_WIDTH, 32: number of low IV bits incremented per block in CTR mode (1..128).
- TIMEOUT, 64: maximum cycles to wait for core done before error.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset.
- msg_start  in  1  one-cycle pulse; latches mode/dir/key/iv; honoured only when busy=0.
- mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved.
- dir  in  1  0 encrypt, 1 decrypt.
- key  in  128  message key.
- iv  in  128  CBC IV or CTR initial counter block.
- in_valid / in_ready  in/out  1  input block handshake.
- in_data  in  128  plaintext (enc) or ciphertext (dec).
- in_last  in  1  final block of message.
- out_valid / out_ready  out/in  1  output block handshake.
- out_data  out  128  result block.
- out_last  out  1  final result block.
- busy  out  1  message in progress.
- err  out  1  sticky; set on reserved mode or timeout, cleared by next accepted msg_start.
- core_data, core_key  out  128  to core.
- core_start_enc, core_start_dec  out  1  one-cycle start pulses.
- core_done_enc, core_done_dec  in  1  core completion.
- core_cipher, core_plain  in  128  core results.

## Operation
- FSM: IDLE -> WAIT_IN -> ISSUE -> WAIT_CORE -> OUT -> (WAIT_IN, or IDLE if the block was last).
- IDLE: on msg_start, latch key to core_key, iv to chain/ctr register, and mode/dir. Set busy. If mode=11, set err and stay IDLE with busy=0.
- WAIT_IN: in_ready=1. On in_valid, latch in_data and in_last.
- ISSUE: drive core_data and a single start pulse:
  - ECB: core_data=in; start_enc if dir=0, else start_dec.
  - CBC enc: core_data=in^chain; start_enc.
  - CBC dec: core_data=in; start_dec.
  - CTR: core_data=ctr; always start_enc.
- WAIT_CORE: wait for the done that matches the issued start; result is taken from core_cipher (enc) or core_plain (dec).
- OUT: out_data is registered as follows:
  - ECB: result.
  - CBC enc: result, and chain<=result.
  - CBC dec: result^chain, and chain<=latched in.
  - CTR: in^result, and ctr[CTR_WIDTH-1:0]<=+1, wrapping mod 2^CTR_WIDTH with no carry into the upper bits.
- OUT hold: out_valid is held with data stable until out_ready. On the handshake, go to WAIT_IN, or to IDLE with busy=0 if out_last.
- Timeout: the wait counter exceeds TIMEOUT in WAIT_CORE -> err=1, go to IDLE, busy=0, and drop the block with no output.
- msg_start while busy=1 is ignored.

## Timing
- Reset values: in_ready, out_valid, out_last, busy, err, core_start_* = 0; out_data, core_data, core_key, chain, ctr = 0; FSM=IDLE.
- Reset mid-message aborts immediately; no start pulse is issued afterward.
- msg_start at cycle N -> busy=1 and in_ready=1 at N+1.
- in handshake at cycle N -> start pulse at N+1 (exactly one cycle) -> done at cycle M -> out_valid=1 at M+1.
- Per-block latency is therefore core latency + 2; throughput is one block per core latency + 3 when out_ready=1.
- A done arriving in the same cycle as the timeout limit counts as success.
- A done of the wrong type is ignored.
- in_ready=0 whenever the FSM is not in WAIT_IN. out_valid never drops without out_ready.

## Structure
- Package aes_mode_pkg holds:
  - mode encodings (MODE_ECB/CBC/CTR).
  - FSM state enum.
  - BLOCK_W=128.
- No sub-module is needed. The CTR increment is an inline masked adder; the AES core is instantiated by the parent, not inside this block.

## Test plan
- ECB encrypt, key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff, last=1 -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, busy falls.
- ECB decrypt, key 5468617473206d79204b756e67204675, in 29c3505f571420f6402299b31a02d73a -> out 54776f204f6e65204e696e652054776f.
- CBC, iv=0, 2 blocks, encrypt then decrypt:
  - encrypt block 1 equals the ECB result above.
  - decrypt returns the original plaintext.
  - out_ready held low for 5 cycles -> data stable, no extra start pulses.
- CTR, iv 00112233445566778899aabbccddeeff, in 0, key 000102..0f -> out 69c4e0d86a7b0430d8cdb78070b4c55a.
- CTR wrap, iv low 32 bits ffffffff -> second core_data has low word 00000000 and upper 96 bits unchanged.
- Error paths, checked separately:
  - mode=11 -> err=1, busy=0.
  - core done withheld -> err=1 after TIMEOUT cycles, IDLE.
  - reset asserted in WAIT_CORE -> all outputs at reset values next cycle.
  - next msg_start clears err.
